mux_sel_sequencer: RTL

//  Upstream driver for the 8-to-1 MUX stage: accepts one 8-bit word, holds it on
//  the MUX data inputs a..h and steps select s2..s0 through all 8 positions, so
//  the MUX output emits the word serially (parallel-to-serial front end).

---
 rtl/mux_sel_sequencer_pkg.sv | 27 ++
 rtl/mux_sel_sequencer_if.sv | 24 ++
 rtl/mux_sel_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the 8-to-1 MUX select sequencer.
// Select start/end points are derived from the serialisation order.
package mux_sel_sequencer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic sel_t sel_first(input bit lsb_first);
    return lsb_first ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
  endfunction

  function automatic sel_t sel_last(input bit lsb_first);
    return lsb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Load handshake plus MUX-facing data/select/status lines of the sequencer.
// slave = sequencer side, master = upstream/bench side.
interface mux_sel_sequencer_if;
  import mux_sel_sequencer_pkg::*;

  logic  load_valid;
  word_t load_data;
  logic  load_ready;
  logic  a, b, c, d, e, f, g, h;
  logic  s0, s1, s2;
  logic  bit_valid;
  logic  done;

  modport slave (
    input  load_valid, load_data,
    output load_ready, a, b, c, d, e, f, g, h, s0, s1, s2, bit_valid, done
  );

  modport master (
    output load_valid, load_data,
    input  load_ready, a, b, c, d, e, f, g, h, s0, s1, s2, bit_valid, done
  );

endinterface

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial front end: latches one word onto the MUX data inputs and
// steps the MUX select through all eight positions, HOLD cycles per position.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned HOLD      = 1
) (
  input  logic                clk,
  input  logic                rst,
  mux_sel_sequencer_if.slave  bus
);

  localparam sel_t SEL_FIRST = sel_first(LSB_FIRST);
  localparam sel_t SEL_LAST  = sel_last(LSB_FIRST);
  localparam cnt_t CNT_LAST  = CNT_W'(HOLD - 1);

  state_e state_q, state_d;
  word_t  word_q,  word_d;
  sel_t   sel_q,   sel_d;
  cnt_t   cnt_q,   cnt_d;
  logic   ready_q, ready_d;
  logic   valid_q, valid_d;
  logic   done_q,  done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      sel_q   <= SEL_FIRST;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next state; status flags are decoded from the next state so they land registered.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        sel_d = SEL_FIRST;
        cnt_d = '0;
        if (bus.load_valid) begin
          word_d  = bus.load_data;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sel_q == SEL_LAST) begin
            state_d = ST_DONE;
          end else begin
            sel_d = LSB_FIRST ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sel_d   = SEL_FIRST;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_FIRST;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_SEND);
    done_d  = (state_d == ST_DONE);
  end

  assign bus.load_ready = ready_q;
  assign bus.bit_valid  = valid_q;
  assign bus.done       = done_q;
  assign {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = word_q;
  assign {bus.s2, bus.s1, bus.s0} = sel_q;

endmodule
